// File: rtl/dmem_arbiter.sv
// Sequencer/arbiter for the MEM-stage data memory: the pipeline and an external
// loader port share one memory, with programmable wait states and alternating priority.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_memread,
    input  logic              pipe_memwrite,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_done,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, PIPE = 2'd1, EXT = 2'd2, EXT_DONE = 2'd3} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              last_owner;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_we;
    logic [DATA_W-1:0] pipe_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;
    logic              ext_gnt_q;
    logic              pipe_req, pick_pipe, pick_ext, last_cyc;

    assign pipe_req  = pipe_memread | pipe_memwrite;
    // Under contention the side that did not go last wins.
    assign pick_pipe = pipe_req & (~ext_req | last_owner);
    assign pick_ext  = ext_req & ~pick_pipe;
    assign last_cyc  = (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (pick_pipe)     state_nx = PIPE;
                      else if (pick_ext) state_nx = EXT;
            PIPE:     if (last_cyc)      state_nx = IDLE;
            EXT:      if (last_cyc)      state_nx = EXT_DONE;
            EXT_DONE:                    state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= 4'd0;
            last_owner   <= 1'b1;
            acc_addr     <= '0;
            acc_wdata    <= '0;
            acc_we       <= 1'b0;
            pipe_rdata_q <= '0;
            ext_rdata_q  <= '0;
            ext_gnt_q    <= 1'b0;
        end else begin
            ext_gnt_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_pipe) begin
                        cnt       <= WAIT_LD;
                        acc_addr  <= pipe_addr;
                        acc_wdata <= pipe_wdata;
                        acc_we    <= pipe_memwrite;
                    end else if (pick_ext) begin
                        cnt       <= WAIT_LD;
                        acc_addr  <= ext_addr;
                        acc_wdata <= ext_wdata;
                        acc_we    <= ext_we;
                        ext_gnt_q <= 1'b1;
                    end
                end
                PIPE, EXT: begin
                    if (!last_cyc) begin
                        cnt <= cnt - 4'd1;
                    end else if (state == PIPE) begin
                        last_owner <= 1'b0;
                        if (!acc_we) pipe_rdata_q <= mem_rdata;
                    end else begin
                        last_owner <= 1'b1;
                        if (!acc_we) ext_rdata_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ext_done   = 1'b0;
        pipe_rdata = pipe_rdata_q;
        case (state)
            PIPE, EXT: begin
                mem_write = acc_we;
                mem_read  = ~acc_we;
            end
            EXT_DONE: ext_done = 1'b1;
            default: ;
        endcase
        // Bypass so the MEM/WB register can capture read data at the releasing edge.
        if (state == PIPE && last_cyc && !acc_we) pipe_rdata = mem_rdata;
    end

    // Gated by rst_n so a reset frees the pipeline even with a request still asserted.
    assign pipe_stall = rst_n & pipe_req & ~(state == PIPE && last_cyc);
    assign mem_addr   = acc_addr;
    assign mem_wdata  = acc_wdata;
    assign ext_gnt    = ext_gnt_q;
    assign ext_rdata  = ext_rdata_q;
endmodule
